dpb_slot_scheduler: RTL
=======================

DPB_SLOT_SCHEDULER -- requirements
Module: dpb_slot_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 40: idle cycles between the end of one UDP packet and the next issue.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 65535: maximum cycles to wait for i_udp_done.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports i_pclk and i_rst_n.
REQ-004 SHALL have the following ports:
- i_pclk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_alloc_req  in  1  producer requests a free DPB slot (level).
- o_alloc_gnt  out  1  one-cycle grant pulse.
- o_alloc_slot  out  4  granted slot index; valid with o_alloc_gnt.
- o_free_cnt  out  5  number of free slots, 0..16.
- i_commit  in  1  one-cycle pulse: slot filled.
- i_commit_slot  in  4  slot being committed.
- i_commit_words  in  7  128-bit words written, 1..127.
- i_commit_bytes  in  5  valid bytes in the last word, 1..16; used only when i_commit_last=1.
- i_commit_last  in  1  slot holds the final chunk of a JPEG frame.
- i_commit_frame  in  15  MJPEG frame rank.
- o_udp_en  out  1  one-cycle issue pulse to the UDP engine.
- o_udp_slot  out  4  DPB port-B address bits [10:7]; held until the packet completes.
- o_udp_len  out  16  payload bytes.
- o_udp_last  out  1  last-frame flag.
- o_udp_frame  out  15  frame rank.
- o_udp_ipv4_id  out  16  IPv4 identification.
- i_udp_busy  in  1  UDP engine busy.
- i_udp_done  in  1  one-cycle pulse: packet sent.
- o_err  out  1  sticky error flag.

Function
REQ-005 SHALL track 16 slots in a free bitmap; all slots free after reset.
REQ-006 SHALL grant on a cycle when i_alloc_req=1 and at least one slot is free: o_alloc_gnt=1 on the next cycle, with the lowest free index; that slot is marked allocated. Maximum one grant per cycle. No grant while o_free_cnt=0.
REQ-007 SHALL handle i_commit on an allocated, not-yet-committed slot as follows: store the descriptor and push the index to a 16-entry FIFO.
- Length for non-last: words*16.
- Length for last: (words-1)*16 + bytes.
- Arithmetic is zero-extended to 16 bits.
REQ-008 SHALL ignore i_commit to a free or already-queued slot and set o_err.
REQ-009 SHALL run the FSM states IDLE, ISSUE, WAIT_DONE, GAP.
REQ-010 SHALL leave IDLE for ISSUE when the FIFO is non-empty and i_udp_busy=0, popping the head index and loading the o_udp_* outputs.
REQ-011 ISSUE SHALL assert o_udp_en for exactly 1 cycle, then go to WAIT_DONE.
REQ-012 WAIT_DONE SHALL go to GAP on i_udp_done. If DONE_TIMEOUT cycles elapse first, it SHALL set o_err and go to GAP.
REQ-013 GAP SHALL:
- free the slot on its first cycle;
- increment o_udp_ipv4_id by 1 (wraps 0xFFFF to 0);
- count GAP_CYCLES cycles;
- return to IDLE.
REQ-014 When a commit and an IDLE dispatch with an empty FIFO occur in the same cycle, the dispatch SHALL happen on the following cycle (minimum latency commit to o_udp_en = 3 cycles).
REQ-015 A slot freed in cycle N SHALL be grantable no earlier than cycle N+1. A simultaneous free and alloc SHALL grant a different free slot, or none.
REQ-016 Commits SHALL be accepted in any FSM state. FIFO overflow is impossible because each slot is queued at most once.

Reset
REQ-017 Reset SHALL set:
- all outputs to 0, except o_free_cnt=16;
- FSM to IDLE;
- FIFO empty;
- bitmap all free;
- counters to 0.
REQ-018 Reset mid-packet SHALL abandon the packet and discard all queued and allocated slots. No o_udp_en SHALL be issued until after reset deasserts.

Structure
REQ-019 Package dpb_pkg SHALL hold:
- SLOT_W=4 and NSLOT=16;
- the descriptor struct (len 16, last 1, frame 15);
- the FSM state enum.
REQ-020 The ready queue SHALL be a sub-module dpb_slot_fifo: 16x4, synchronous, push/pop/empty/full.

Verification
REQ-021 Alloc 16 times, then request again -> slots 0..15 granted in order, o_free_cnt=0, 17th request gets no grant.
REQ-022 Commit slot 3 with words=5, last=0; commit slot 7 with words=4, bytes=9, last=1 -> o_udp_len 80 then 57, o_udp_last 0 then 1, issued in commit order.
REQ-023 i_udp_done 10 cycles after o_udp_en, with GAP_CYCLES=40 -> next o_udp_en no earlier than 42 cycles after done, and o_udp_ipv4_id increments by 1.
REQ-024 Hold i_udp_busy=1 with the FIFO non-empty -> no o_udp_en until busy drops.
REQ-025 Commit to a free slot, and withhold done with DONE_TIMEOUT=100 -> o_err=1, slot freed after timeout.
REQ-026 Assert i_rst_n=0 in WAIT_DONE -> all outputs reset, o_free_cnt=16.

Source files
------------

// File: rtl/dpb_pkg.sv
// Shared types and helpers for the DPB slot scheduler: slot geometry, descriptor payload, FSM states.
package dpb_pkg;

  localparam int unsigned SLOT_W  = 4;
  localparam int unsigned NSLOT   = 16;
  localparam int unsigned FREE_W  = SLOT_W + 1;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned FRAME_W = 15;
  localparam int unsigned WORDS_W = 7;
  localparam int unsigned BYTES_W = 5;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic               last;
    logic [FRAME_W-1:0] frame;
  } dpb_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } dpb_state_e;

  // Index of the lowest set bit; 0 when the map is empty (callers gate on |map).
  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NSLOT-1:0] map);
    lowest_set = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (map[i]) lowest_set = SLOT_W'(i);
    end
  endfunction

  // Payload bytes of a slot: full 16-byte words, with a partial final word on the last chunk.
  function automatic logic [LEN_W-1:0] desc_len(input logic [WORDS_W-1:0] words,
                                                input logic [BYTES_W-1:0] bytes,
                                                input logic               last);
    if (last) desc_len = ((LEN_W'(words) - LEN_W'(1)) << 4) + LEN_W'(bytes);
    else      desc_len = LEN_W'(words) << 4;
  endfunction

endpackage

// File: rtl/dpb_slot_fifo.sv
// 16-entry ready queue of committed slot indices, in commit order.
module dpb_slot_fifo
  import dpb_pkg::*;
(
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic [SLOT_W-1:0] push_slot,
  input  logic              pop,
  output logic [SLOT_W-1:0] head_slot_c,
  output logic              empty,
  output logic              full
);

  logic [SLOT_W-1:0] mem_q [NSLOT];
  logic [SLOT_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FREE_W-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign count_d     = count_q + FREE_W'(do_push) - FREE_W'(do_pop);
  assign head_slot_c = mem_q[rd_ptr_q];

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_slot;
        wr_ptr_q        <= wr_ptr_q + SLOT_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + SLOT_W'(1);
      count_q <= count_d;
      empty   <= (count_d == '0);
      full    <= (count_d == FREE_W'(NSLOT));
    end
  end

endmodule

// File: rtl/dpb_slot_scheduler.sv
// Allocates DPB slots to the JPEG producer and paces committed slots out to the UDP engine.
module dpb_slot_scheduler
  import dpb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 40,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic                i_pclk,
  input  logic                i_rst_n,
  input  logic                i_alloc_req,
  output logic                o_alloc_gnt,
  output logic [SLOT_W-1:0]   o_alloc_slot,
  output logic [FREE_W-1:0]   o_free_cnt,
  input  logic                i_commit,
  input  logic [SLOT_W-1:0]   i_commit_slot,
  input  logic [WORDS_W-1:0]  i_commit_words,
  input  logic [BYTES_W-1:0]  i_commit_bytes,
  input  logic                i_commit_last,
  input  logic [FRAME_W-1:0]  i_commit_frame,
  output logic                o_udp_en,
  output logic [SLOT_W-1:0]   o_udp_slot,
  output logic [LEN_W-1:0]    o_udp_len,
  output logic                o_udp_last,
  output logic [FRAME_W-1:0]  o_udp_frame,
  output logic [15:0]         o_udp_ipv4_id,
  input  logic                i_udp_busy,
  input  logic                i_udp_done,
  output logic                o_err
);

  localparam int unsigned CNT_MAX = (DONE_TIMEOUT > GAP_CYCLES) ? DONE_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  dpb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NSLOT-1:0]  free_map_q, queued_q;
  logic [NSLOT-1:0]  alloc_mask, free_mask, commit_mask;
  dpb_desc_t         desc_q [NSLOT];
  logic              do_alloc, commit_ok, pop, udp_en_d, tx_free, timeout;
  logic [SLOT_W-1:0] alloc_slot, head_slot;
  logic              fifo_empty, fifo_full;

  // Allocation reads the pre-free bitmap, so a slot released this cycle is never granted this cycle.
  assign do_alloc    = i_alloc_req && (|free_map_q);
  assign alloc_slot  = lowest_set(free_map_q);
  assign commit_ok   = i_commit && !free_map_q[i_commit_slot] && !queued_q[i_commit_slot] && !fifo_full;
  assign alloc_mask  = do_alloc  ? (NSLOT'(1) << alloc_slot)    : '0;
  assign commit_mask = commit_ok ? (NSLOT'(1) << i_commit_slot) : '0;
  assign free_mask   = tx_free   ? (NSLOT'(1) << o_udp_slot)    : '0;

  dpb_slot_fifo u_fifo (
    .i_pclk      (i_pclk),
    .i_rst_n     (i_rst_n),
    .push        (commit_ok),
    .push_slot   (i_commit_slot),
    .pop         (pop),
    .head_slot_c (head_slot),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    udp_en_d = 1'b0;
    tx_free  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !i_udp_busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        udp_en_d = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_udp_done) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
          timeout = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        tx_free = (cnt_q == '0);
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot bookkeeping: grant, commit and release.
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      free_map_q   <= '1;
      queued_q     <= '0;
      o_free_cnt   <= FREE_W'(NSLOT);
      o_alloc_gnt  <= 1'b0;
      o_alloc_slot <= '0;
      o_err        <= 1'b0;
      for (int i = 0; i < NSLOT; i++) desc_q[i] <= '0;
    end else begin
      free_map_q  <= (free_map_q & ~alloc_mask) | free_mask;
      queued_q    <= (queued_q | commit_mask) & ~free_mask;
      o_free_cnt  <= o_free_cnt - FREE_W'(do_alloc) + FREE_W'(tx_free);
      o_alloc_gnt <= do_alloc;
      if (do_alloc) o_alloc_slot <= alloc_slot;
      if (commit_ok) begin
        desc_q[i_commit_slot] <= '{len:   desc_len(i_commit_words, i_commit_bytes, i_commit_last),
                                   last:  i_commit_last,
                                   frame: i_commit_frame};
      end
      o_err <= o_err | (i_commit && !commit_ok) | timeout;
    end
  end

  // UDP descriptor outputs are latched at dispatch and held until the next one.
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_udp_en      <= 1'b0;
      o_udp_slot    <= '0;
      o_udp_len     <= '0;
      o_udp_last    <= 1'b0;
      o_udp_frame   <= '0;
      o_udp_ipv4_id <= '0;
    end else begin
      o_udp_en <= udp_en_d;
      if (pop) begin
        o_udp_slot  <= head_slot;
        o_udp_len   <= desc_q[head_slot].len;
        o_udp_last  <= desc_q[head_slot].last;
        o_udp_frame <= desc_q[head_slot].frame;
      end
      if (tx_free) o_udp_ipv4_id <= o_udp_ipv4_id + 16'd1;
    end
  end

endmodule
